// File: rtl/dds_cmd_parser.sv
// rtl/dds_cmd_parser.sv - UART byte-stream command frame decoder for the DDS control registers.
// Optional checksum byte compiled in with `define DDS_CMD_CHECKSUM_EN.
module dds_cmd_parser #(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          TIMEOUT_US = 100,
  parameter logic [31:0] FTW_RST    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] ftw,
  output logic [31:0] phase_off,
  output logic [1:0]  wave_sel,
  output logic        cfg_update,
  output logic        frame_err
);

  localparam int TIMEOUT_CYC = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
  localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC - 1);
`ifdef DDS_CMD_CHECKSUM_EN
  localparam int SH_W = 32;
`else
  // Without a checksum byte the last payload byte is applied straight off the bus.
  localparam int SH_W = 24;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHK} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0]       ftw_q, ftw_d;
  logic [31:0]       phase_q, phase_d;
  logic [1:0]        wave_q, wave_d;
  logic              cfg_update_q, cfg_update_d;
  logic              frame_err_q, frame_err_d;
  logic              apply;
  logic              timeout;
  logic [31:0]       payload;
`ifdef DDS_CMD_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
  assign payload = shift_q;
`else
  assign payload = {shift_q, rx_data};
`endif

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    cmd_d        = cmd_q;
    shift_d      = shift_q;
    ftw_d        = ftw_q;
    phase_d      = phase_q;
    wave_d       = wave_q;
    cfg_update_d = 1'b0;
    frame_err_d  = 1'b0;
    apply        = 1'b0;
`ifdef DDS_CMD_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    // An arriving byte always beats an expiring gap counter.
    timeout = (state_q != S_IDLE) && !rx_valid && (gap_cnt_q == GAP_MAX);
    if (state_q == S_IDLE || rx_valid || timeout) begin
      gap_cnt_d = '0;
    end else begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == 8'hA5) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          if (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03) begin
            cmd_d      = rx_data[1:0];
            byte_cnt_d = 2'd0;
            state_d    = S_PAYLOAD;
`ifdef DDS_CMD_CHECKSUM_EN
            chk_d      = rx_data;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          shift_d    = {shift_q[SH_W-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef DDS_CMD_CHECKSUM_EN
          chk_d      = chk_q ^ rx_data;
          if (byte_cnt_q == 2'd3) state_d = S_CHK;
`else
          if (byte_cnt_q == 2'd3) begin
            apply   = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef DDS_CMD_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) apply = 1'b1;
          else                  frame_err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end

    if (apply) begin
      cfg_update_d = 1'b1;
      case (cmd_q)
        2'd1:    ftw_d   = payload;
        2'd2:    phase_d = payload;
        2'd3:    wave_d  = payload[1:0];
        default: cfg_update_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      cmd_q        <= 2'd0;
      shift_q      <= '0;
      gap_cnt_q    <= '0;
      ftw_q        <= FTW_RST;
      phase_q      <= 32'h0;
      wave_q       <= 2'd0;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef DDS_CMD_CHECKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      cmd_q        <= cmd_d;
      shift_q      <= shift_d;
      gap_cnt_q    <= gap_cnt_d;
      ftw_q        <= ftw_d;
      phase_q      <= phase_d;
      wave_q       <= wave_d;
      cfg_update_q <= cfg_update_d;
      frame_err_q  <= frame_err_d;
`ifdef DDS_CMD_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign ftw        = ftw_q;
  assign phase_off  = phase_q;
  assign wave_sel   = wave_q;
  assign cfg_update = cfg_update_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// tb/tb_dds_cmd_parser.sv - randomized frame stream checked against a byte-level frame model.
// Honours `define DDS_CMD_CHECKSUM_EN like the design.
module tb_dds_cmd_parser;

  localparam int TC = 10_000;
`ifdef DDS_CMD_CHECKSUM_EN
  localparam int BODY_LEN = 6;
  localparam bit CHK_EN   = 1'b1;
`else
  localparam int BODY_LEN = 5;
  localparam bit CHK_EN   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] ftw;
  logic [31:0] phase_off;
  logic [1:0]  wave_sel;
  logic        cfg_update;
  logic        frame_err;

  dds_cmd_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ftw        (ftw),
    .phase_off  (phase_off),
    .wave_sel   (wave_sel),
    .cfg_update (cfg_update),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_cfg;
    logic [31:0] ftw;
    logic [31:0] ph;
    logic [1:0]  ws;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  err_cnt = 0;
  int  chk_cnt = 0;
  int  overlap_cnt = 0;

  // Reference model state: bytes collected after SYNC, plus the register image.
  bit          in_frame;
  logic [7:0]  fbuf[$];
  int          idle_run;
  logic [31:0] m_ftw, m_ph;
  logic [1:0]  m_ws;

  always @(negedge clk) begin
    ev_t e;
    if (cfg_update && frame_err) overlap_cnt++;
    if (cfg_update) begin
      e.is_cfg = 1'b1; e.ftw = ftw; e.ph = phase_off; e.ws = wave_sel;
      obs_q.push_back(e);
    end
    if (frame_err) begin
      e.is_cfg = 1'b0; e.ftw = ftw; e.ph = phase_off; e.ws = wave_sel;
      obs_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input bit is_cfg);
    ev_t e;
    e.is_cfg = is_cfg; e.ftw = m_ftw; e.ph = m_ph; e.ws = m_ws;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    fbuf.delete();
    idle_run = 0;
    m_ftw = 32'h0; m_ph = 32'h0; m_ws = 2'd0;
  endtask

  task automatic model_flush();
    if (in_frame && idle_run >= TC) begin
      push_ev(1'b0);
      in_frame = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] pl;
    logic [7:0]  x;
    model_flush();
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1'b1;
        fbuf.delete();
      end
      return;
    end
    fbuf.push_back(b);
    if (fbuf.size() == 1 && (b < 8'd1 || b > 8'd3)) begin
      push_ev(1'b0);
      in_frame = 1'b0;
    end else if (fbuf.size() == BODY_LEN) begin
      pl = {fbuf[1], fbuf[2], fbuf[3], fbuf[4]};
      x  = fbuf[0] ^ fbuf[1] ^ fbuf[2] ^ fbuf[3] ^ fbuf[4];
      if (!CHK_EN || x == fbuf[BODY_LEN-1]) begin
        case (fbuf[0])
          8'd1:    m_ftw = pl;
          8'd2:    m_ph  = pl;
          default: m_ws  = pl[1:0];
        endcase
        push_ev(1'b1);
      end else begin
        push_ev(1'b0);
      end
      in_frame = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    idle_run += n;
  endtask

  task automatic tx(input logic [7:0] b);
    model_byte(b);
    idle_run = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] cmd, input logic [31:0] pl, input bit bad_chk,
                          input int gapmax);
    logic [7:0] bytes[$];
    logic [7:0] x;
    x = cmd ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
    bytes = '{8'hA5, cmd, pl[31:24], pl[23:16], pl[15:8], pl[7:0]};
    if (CHK_EN) bytes.push_back(bad_chk ? ~x : x);
    foreach (bytes[i]) begin
      if (i != 0 && gapmax > 0) idle($urandom_range(gapmax));
      tx(bytes[i]);
    end
  endtask

  task automatic checkpoint(input string tag);
    int n;
    idle(3);
    model_flush();
    #1;
    check({tag, "_ev_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_ev_kind"}, 32'(obs_q[i].is_cfg), 32'(exp_q[i].is_cfg));
      check({tag, "_ftw"},     obs_q[i].ftw,         exp_q[i].ftw);
      check({tag, "_phase"},   obs_q[i].ph,          exp_q[i].ph);
      check({tag, "_wave"},    32'(obs_q[i].ws),     32'(exp_q[i].ws));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_ftw_reg"},   ftw,              m_ftw);
    check({tag, "_phase_reg"}, phase_off,        m_ph);
    check({tag, "_wave_reg"},  32'(wave_sel),    32'(m_ws));
    check({tag, "_cfg_idle"},  32'(cfg_update),  32'd0);
    check({tag, "_err_idle"},  32'(frame_err),   32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_regs("reset");

    // Basic ftw write with exact apply latency and single-cycle pulse.
    tx_frame(8'h01, 32'h1234_5678, 1'b0, 0);
    #1;
    check("lat_cfg_update", 32'(cfg_update), 32'd1);
    check("lat_ftw", ftw, 32'h1234_5678);
    idle(1);
    #1;
    check("lat_cfg_pulse_end", 32'(cfg_update), 32'd0);
    checkpoint("ftw");
    check_regs("ftw");

    tx_frame(8'h02, 32'h0000_8000, 1'b0, 0);
    tx_frame(8'h03, 32'hFFFF_FFFE, 1'b0, 0);
    checkpoint("ph_wave");
    check_regs("ph_wave");

    // Junk dropped in IDLE, bad command rejected, then recovery.
    tx(8'h00); tx(8'h13); tx(8'hFF);
    tx(8'hA5); tx(8'h07);
    tx_frame(8'h01, 32'hCAFE_0001, 1'b0, 0);
    checkpoint("badcmd");

    // Stalled frame times out.
    tx(8'hA5); tx(8'h01); tx(8'hAA);
    idle(TC);
    checkpoint("timeout");
    check_regs("timeout");
    tx_frame(8'h01, 32'h0BAD_F00D, 1'b0, 0);
    checkpoint("post_timeout");

    // Gap of TIMEOUT_CYC-1 idle cycles survives; TIMEOUT_CYC does not.
    tx(8'hA5); tx(8'h02); tx(8'h12);
    idle(TC - 1);
    tx(8'h34); tx(8'h56); tx(8'h78);
    if (CHK_EN) tx(8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    checkpoint("gap_edge_ok");
    tx(8'hA5); tx(8'h03); tx(8'h00);
    idle(TC);
    tx(8'h00); tx(8'h00); tx(8'h01);
    if (CHK_EN) tx(8'h02);
    checkpoint("gap_edge_expire");
    check_regs("gap_edge");

    if (CHK_EN) begin
      tx_frame(8'h01, 32'h1234_5678, 1'b1, 0);
      checkpoint("bad_chk");
      check_regs("bad_chk");
    end

    // Reset mid-frame aborts it; the trailing bytes land in IDLE.
    tx(8'hA5); tx(8'h01); tx(8'h12); tx(8'h34);
    checkpoint("pre_reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tx(8'h56); tx(8'h78);
    if (CHK_EN) tx(8'h09);
    checkpoint("mid_reset");
    check_regs("mid_reset");

    // Random mix of well-formed frames, corrupt frames and loose bytes.
    for (int it = 0; it < 80; it++) begin
      int kind;
      kind = $urandom_range(9);
      if (kind < 5) begin
        tx_frame(8'($urandom_range(3, 1)), $urandom, 1'b0, 2);
      end else if (kind == 5) begin
        tx_frame(8'($urandom_range(3, 1)), $urandom, 1'b1, 2);
      end else if (kind == 6) begin
        tx(8'hA5);
      end else begin
        tx(8'($urandom));
      end
      if ($urandom_range(3) == 0) idle($urandom_range(4));
      if (it % 10 == 9) checkpoint("rand");
    end
    idle(TC + 2);
    checkpoint("rand_end");
    check_regs("rand_end");

    check("cfg_err_overlap", 32'(overlap_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
